// File: rtl/riscv_mdu_pkg.sv
// riscv_mdu_pkg: op/state enums and operand-signedness decode shared by the riscv_mdu files
package riscv_mdu_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIN} mdu_state_e;
  function automatic logic is_signed_a(mdu_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction
  function automatic logic is_signed_b(mdu_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction
endpackage

// File: rtl/riscv_mdu_fast_mul.sv
// riscv_mdu_fast_mul: combinational signed/unsigned DATA_W x DATA_W multiplier (a, b, signed_a, signed_b in; 2*DATA_W prod out), built only with RISCV_MDU_FAST_MUL_EN
`ifdef RISCV_MDU_FAST_MUL_EN
module riscv_mdu_fast_mul #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic                signed_a,
  input  logic                signed_b,
  output logic [2*DATA_W-1:0] prod
);
  logic signed [DATA_W:0] ea, eb;
  logic signed [2*DATA_W+1:0] p;
  assign ea = {signed_a & a[DATA_W-1], a};
  assign eb = {signed_b & b[DATA_W-1], b};
  assign p = (2*DATA_W+2)'(ea) * (2*DATA_W+2)'(eb);
  assign prod = p[2*DATA_W-1:0];
endmodule
`endif

// File: rtl/riscv_mdu.sv
// riscv_mdu: iterative RV32M mul/div unit (clk, reset active-low async, start, flush, Funct3, op_a, op_b in; busy, done, result out; RISCV_MDU_FAST_MUL_EN selects a single-cycle multiplier)
module riscv_mdu
  import riscv_mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic [2:0]        Funct3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  mdu_state_e state, state_d;
  mdu_op_e op, op_in;
  logic [2*DATA_W-1:0] acc, acc_step, mres, fast_prod;
  logic [DATA_W-1:0] opd, a_mag, b_mag, quo, rem, fin_val, spec_val;
  logic [DATA_W:0] sum, sh, diff;
  logic [CNT_W-1:0] cnt;
  logic neg_q, neg_r, raw, a_neg, b_neg, in_mul, in_special, fast, accept, last, mul_op, hi_sel;
  assign op_in = mdu_op_e'(Funct3);
  assign in_mul = !Funct3[2];
  assign a_neg = is_signed_a(op_in) && op_a[DATA_W-1];
  assign b_neg = is_signed_b(op_in) && op_b[DATA_W-1];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;
  assign in_special = !in_mul && (op_b == '0 ||
    (is_signed_a(op_in) && op_a == {1'b1, {(DATA_W-1){1'b0}}} && op_b == '1));
  assign spec_val = op_b == '0 ? (Funct3[1] ? op_a : '1) : (Funct3[1] ? '0 : op_a);
`ifdef RISCV_MDU_FAST_MUL_EN
  riscv_mdu_fast_mul #(.DATA_W(DATA_W)) u_fast_mul (
    .a(op_a),
    .b(op_b),
    .signed_a(is_signed_a(op_in)),
    .signed_b(is_signed_b(op_in)),
    .prod(fast_prod)
  );
  assign fast = in_mul;
`else
  assign fast_prod = '0;
  assign fast = 1'b0;
`endif
  assign accept = state == IDLE && start && !flush;
  assign last = cnt == CNT_W'(DATA_W - 1);
  assign busy = state != IDLE;
  always_comb begin
    state_d = state;
    if (flush) state_d = IDLE;
    else if (state == IDLE && start) state_d = (in_special || fast) ? FIN : CALC;
    else if (state == CALC && last) state_d = FIN;
    else if (state == FIN) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_d;
  // acc holds {partial product} for multiply and {remainder, quotient} for divide;
  // opd holds the multiplicand or divisor magnitude.
  assign mul_op = !op[2];
  assign hi_sel = op inside {OP_MULH, OP_MULHSU, OP_MULHU};
  assign sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opd} : '0);
  assign sh = acc[2*DATA_W-1:DATA_W-1];
  assign diff = sh - {1'b0, opd};
  assign acc_step = mul_op ? {sum, acc[DATA_W-1:1]}
                           : {diff[DATA_W] ? sh[DATA_W-1:0] : diff[DATA_W-1:0], acc[DATA_W-2:0], !diff[DATA_W]};
  assign mres = neg_q ? -acc : acc;
  assign quo = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
  assign rem = neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
  // raw: acc already holds the final signed value (special case or fast product)
  assign fin_val = raw ? (hi_sel ? acc[2*DATA_W-1:DATA_W] : acc[DATA_W-1:0])
                 : mul_op ? (hi_sel ? mres[2*DATA_W-1:DATA_W] : mres[DATA_W-1:0])
                 : (op[1] ? rem : quo);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      op     <= OP_MUL;
      acc    <= '0;
      opd    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      raw    <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= state == FIN && !flush;
      if (state == FIN && !flush) result <= fin_val;
      if (accept) begin
        op    <= op_in;
        cnt   <= '0;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        raw   <= in_special || fast;
        acc   <= in_special ? {{DATA_W{1'b0}}, spec_val}
               : fast ? fast_prod
               : {{DATA_W{1'b0}}, in_mul ? b_mag : a_mag};
        opd   <= in_mul ? a_mag : b_mag;
      end else if (state == CALC) begin
        acc <= acc_step;
        cnt <= cnt + CNT_W'(1);
      end
    end
endmodule
